conway_window: RTL and testbench



---
 rtl/conway_window.sv | 156 +++++++++++++++
 tb/tb_conway_window.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/conway_window.sv
// Raster-order 3x3 neighbourhood generator feeding the conway rule.
// Define CONWAY_WINDOW_LIVE_COUNT_EN to add the per-frame live-cell count outputs.
module conway_window #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic                          s_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_center,
    output logic [7:0]                    m_neighbors,
    output logic [$clog2(WIDTH)-1:0]      m_col,
    output logic [$clog2(HEIGHT)-1:0]     m_row,
    output logic                          m_last
`ifdef CONWAY_WINDOW_LIVE_COUNT_EN
    ,
    output logic [$clog2(WIDTH*HEIGHT+1)-1:0] live_count,
    output logic                          live_count_valid
`endif
);
    localparam int CW   = $clog2(WIDTH);
    localparam int RW   = $clog2(HEIGHT);
    localparam int NC   = WIDTH * HEIGHT;
    localparam int IW   = $clog2(NC);
    localparam int TAPS = 2 * WIDTH + 3;

    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [IW-1:0] FILL_END = IW'(WIDTH);
    localparam logic [IW-1:0] IN_LAST  = IW'(NC - 1);

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [TAPS-2:0]   sr;
    logic [TAPS-1:0]   taps;
    logic [IW-1:0]     in_cnt;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [7:0]        nb;
    logic              accept;
    logic              flush_step;
    logic              load;
    logic              shift;
    logic              last_cell;

    always_comb begin
        s_ready = 1'b0;
        unique case (state)
            FILL:    s_ready = resetn;
            RUN:     s_ready = resetn && (!m_valid || m_ready);
            default: s_ready = 1'b0;
        endcase
    end

    assign accept     = s_valid && s_ready;
    assign flush_step = (state == FLUSH) && (!m_valid || m_ready);
    assign load       = ((state == RUN) && accept) || flush_step;
    assign shift      = accept || flush_step;
    assign last_cell  = (row == ROW_LAST) && (col == COL_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL:  if (accept && in_cnt == FILL_END) state_nxt = RUN;
            RUN:   if (accept && in_cnt == IN_LAST) state_nxt = FLUSH;
            FLUSH: if (flush_step && last_cell) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // taps[0] is the incoming cell, taps[WIDTH+1] the centre of the window
    assign taps = {sr, (state == FLUSH) ? 1'b0 : s_data};

    always_comb begin
        nb = {taps[0], taps[1], taps[2],
              taps[WIDTH], taps[WIDTH+2],
              taps[2*WIDTH], taps[2*WIDTH+1], taps[2*WIDTH+2]};
        if (col == '0)       nb = nb & 8'b1101_0110;
        if (col == COL_LAST) nb = nb & 8'b0110_1011;
        if (row == '0)       nb = nb & 8'b1111_1000;
        if (row == ROW_LAST) nb = nb & 8'b0001_1111;
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= FILL;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sr          <= '0;
            in_cnt      <= '0;
            col         <= '0;
            row         <= '0;
            m_valid     <= 1'b0;
            m_center    <= 1'b0;
            m_neighbors <= '0;
            m_col       <= '0;
            m_row       <= '0;
            m_last      <= 1'b0;
        end else begin
            if (shift) sr <= taps[TAPS-2:0];
            if (accept) in_cnt <= (in_cnt == IN_LAST) ? '0 : in_cnt + IW'(1);
            if (load) begin
                m_valid     <= 1'b1;
                m_center    <= taps[WIDTH+1];
                m_neighbors <= nb;
                m_col       <= col;
                m_row       <= row;
                m_last      <= last_cell;
                if (last_cell) begin
                    col <= '0;
                    row <= '0;
                end else if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

`ifdef CONWAY_WINDOW_LIVE_COUNT_EN
    localparam int LW = $clog2(NC + 1);
    logic [LW-1:0] acc;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            acc              <= '0;
            live_count       <= '0;
            live_count_valid <= 1'b0;
        end else begin
            live_count_valid <= 1'b0;
            if (accept) begin
                if (in_cnt == IN_LAST) begin
                    live_count       <= acc + LW'(s_data);
                    live_count_valid <= 1'b1;
                    acc              <= '0;
                end else begin
                    acc <= acc + LW'(s_data);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_conway_window.sv
// Self-checking bench for conway_window: grid reference model, spot table,
// backpressure, frame boundaries, reset mid-frame and optional live count.
module tb_conway_window;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_data = 1'b0;
    logic          m_ready = 1'b0;
    logic          s_ready;
    logic          m_valid;
    logic          m_center;
    logic [7:0]    m_neighbors;
    logic [CW-1:0] m_col;
    logic [RW-1:0] m_row;
    logic          m_last;
`ifdef CONWAY_WINDOW_LIVE_COUNT_EN
    logic [$clog2(N+1)-1:0] live_count;
    logic          live_count_valid;
`endif

    conway_window #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_center(m_center), .m_neighbors(m_neighbors),
        .m_col(m_col), .m_row(m_row), .m_last(m_last)
`ifdef CONWAY_WINDOW_LIVE_COUNT_EN
        , .live_count(live_count), .live_count_valid(live_count_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit         cur[N];
    logic       cap_c[N];
    logic [7:0] cap_nb[N];
    logic       cap_last[N];

    typedef struct {
        int         pat;
        int         r;
        int         c;
        logic       ctr;
        logic [7:0] nb;
        logic       last;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Neighbour bits straight from the grid, dead outside its bounds
    function automatic logic [7:0] ref_nb(input int r, input int c);
        int dr[8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
        int dc[8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
        logic [7:0] v = '0;
        for (int i = 0; i < 8; i++) begin
            int rr = r + dr[i];
            int cc = c + dc[i];
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) v[i] = cur[rr*W+cc];
        end
        return v;
    endfunction

    task automatic set_pat(input int p);
        int cnt = 0;
        for (int i = 0; i < N; i++) begin
            case (p)
                0: cur[i] = bit'(((i / W) ^ (i % W)) & 1);
                1: cur[i] = (i == 4 * W + 4);
                2: cur[i] = 1'b1;
                4: cur[i] = bit'($urandom);
                default: cur[i] = 1'b0;
            endcase
        end
        if (p == 5) begin
            while (cnt < 17) begin
                int k = $urandom_range(N - 1);
                if (!cur[k]) begin
                    cur[k] = 1'b1;
                    cnt++;
                end
            end
        end
    endtask

    task automatic run_frame(input int pv, input int pr);
        int idx = 0;
        int got = 0;
        int cyc = 0;
        int ones = 0;
        bit stall = 0;
        bit pulse_exp = 0;
        logic [16:0] held = '0;
        logic [16:0] snap;
        for (int i = 0; i < N; i++) ones += int'(cur[i]);
        while (got < N && cyc < 4000) begin
            s_valid = (idx < N) && ($urandom_range(99) < pv);
            s_data  = s_valid ? cur[idx] : 1'($urandom);
            m_ready = ($urandom_range(99) < pr);
            #1;
            snap = {m_valid, m_center, m_neighbors, m_col, m_row, m_last};
            if (stall) check("hold", snap, held);
            stall = m_valid && !m_ready;
            held  = snap;
            if (idx < W + 1)
                check("s_ready_fill", s_ready, 1);
            else if (idx < N)
                check("s_ready_run", s_ready, !(m_valid && !m_ready));
            else if (got + int'(m_valid) < N)
                check("s_ready_flush", s_ready, 0);
            if (m_valid && m_ready) begin
                check($sformatf("window_%0d", got),
                      {m_center, m_neighbors, m_col, m_row, m_last},
                      {cur[got], ref_nb(got / W, got % W),
                       CW'(got % W), RW'(got / W), got == N - 1});
                cap_c[got]    = m_center;
                cap_nb[got]   = m_neighbors;
                cap_last[got] = m_last;
                got++;
            end
`ifdef CONWAY_WINDOW_LIVE_COUNT_EN
            check("live_valid", live_count_valid, pulse_exp);
            if (pulse_exp) check("live_count", live_count, ones);
`endif
            pulse_exp = s_valid && s_ready && idx == N - 1;
            if (s_valid && s_ready) idx++;
            cyc++;
            @(negedge clk);
        end
        if (got < N) check("timeout", got, N);
        if (pv == 100 && pr == 100) check("cycles", cyc, N + W + 2);
        s_valid = 1'b0;
        m_ready = 1'b0;
    endtask

    task automatic spot(input int p);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pat == p) begin
                int k = vecs[i].r * W + vecs[i].c;
                check($sformatf("spot_p%0d_r%0d_c%0d", p, vecs[i].r, vecs[i].c),
                      {cap_c[k], cap_nb[k], cap_last[k]},
                      {vecs[i].ctr, vecs[i].nb, vecs[i].last});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 1'b0, 8'h50, 1'b0};
        vecs[1]  = '{0, 3, 3, 1'b0, 8'h5A, 1'b0};
        vecs[2]  = '{0, 7, 7, 1'b0, 8'h0A, 1'b1};
        vecs[3]  = '{0, 0, 7, 1'b1, 8'h20, 1'b0};
        vecs[4]  = '{1, 4, 4, 1'b1, 8'h00, 1'b0};
        vecs[5]  = '{1, 3, 3, 1'b0, 8'h80, 1'b0};
        vecs[6]  = '{1, 5, 5, 1'b0, 8'h01, 1'b0};
        vecs[7]  = '{1, 3, 4, 1'b0, 8'h40, 1'b0};
        vecs[8]  = '{2, 0, 0, 1'b1, 8'hD0, 1'b0};
        vecs[9]  = '{2, 3, 3, 1'b1, 8'hFF, 1'b0};
        vecs[10] = '{2, 7, 7, 1'b1, 8'h0B, 1'b1};
        vecs[11] = '{3, 0, 0, 1'b0, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        #1;
        check("reset_s_ready", s_ready, 0);
        check("reset_outputs",
              {m_valid, m_center, m_neighbors, m_col, m_row, m_last}, 0);
`ifdef CONWAY_WINDOW_LIVE_COUNT_EN
        check("reset_live", {live_count_valid, live_count}, 0);
`endif
        resetn = 1'b1;
        #1;
        check("s_ready_after_reset", s_ready, 1);
        @(negedge clk);

        set_pat(0); run_frame(100, 100); spot(0);
        set_pat(1); run_frame(100, 100); spot(1);
        set_pat(0); run_frame(60, 50);   spot(0);
        set_pat(2); run_frame(100, 100); spot(2);
        set_pat(3); run_frame(100, 100); spot(3);

        set_pat(4);
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            s_data = cur[i];
            @(negedge clk);
        end
        resetn  = 1'b0;
        s_valid = 1'b0;
        #1;
        check("midreset_s_ready", s_ready, 0);
        @(negedge clk);
        check("midreset_outputs",
              {m_valid, m_center, m_neighbors, m_col, m_row, m_last}, 0);
        resetn = 1'b1;
        set_pat(4); run_frame(70, 60);

        set_pat(5); run_frame(100, 100);
        repeat (3) begin
            set_pat(4);
            run_frame($urandom_range(30, 100), $urandom_range(30, 100));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
